cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Control sequencer for the 8-bit bus CPU. It replaces the ad-hoc control decode with a single-clock, fully synchronous state machine that walks the T-step microsequence for each opcode and drives the one-hot control word (bus drivers and register loads) to the datapath. It also adds run/halt control, an HLT opcode, illegal-opcode flagging and a retired-instruction counter. It sits between the instruction register (opcode nibble in) and the PC/MAR/RAM/IR/A/B/ALU/output datapath (control strobes out).

## Interface
- No parameters; instruction timing is fixed by the opcode table below.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[7:4]; sampled only in T3 and later steps.
- run  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
- step_req  in  1  single-cycle pulse; executes one instruction from IDLE (see Configuration).
- ctrl  out  14  control word, bit 0 to bit 13 in this order: pc_in, pc_out, pc_add, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, b_out, alu_out, output_in.
- step  out  3  current T-step, 1..5; 0 in IDLE.
- idle  out  1  sequencer is in IDLE.
- hlt  out  1  sticky; an HLT instruction has executed.
- instr_done  out  1  high during the last step of each instruction.
- illegal  out  1  high during T3 of an undefined opcode.
- retired  out  8  count of completed instructions; wraps from 255 to 0.

## Operation
- States: IDLE, T1, T2, T3, T4, T5.
- ctrl, step, instr_done and illegal are combinational decodes of the registered state and opcode.
- The datapath latches on the clock edge that ends each step.
- Fetch, common to all opcodes:
  - T1: pc_out, mar_in.
  - T2: ram_out, ir_in, pc_add.
- Execute, from T3 onward:
  - LDA 0001: T3 ir_out, mar_in; T4 ram_out, a_in. Last step T4.
  - ADD 0010: T3 ir_out, mar_in; T4 ram_out, b_in; T5 alu_out, a_in. Last step T5.
  - OUT 0011: T3 a_out, output_in. Last step T3.
  - JMP 0100: T3 ir_out, pc_in. Last step T3.
  - STA 0101: T3 ir_out, mar_in; T4 a_out, ram_in. Last step T4.
  - HLT 0110: T3 no strobes; sets hlt at the end of T3. Last step T3.
  - NOP 1111: T3 no strobes. Last step T3.
  - Any other opcode: executes as NOP, and illegal=1 in T3.
- At the end of the last step:
  - retired increments.
  - Next state is T1 if run=1 and hlt will not be set; otherwise IDLE.
- IDLE:
  - ctrl=0.
  - Goes to T1 when run=1 and hlt=0.
  - While hlt=1, only reset leaves IDLE; run and step_req are ignored.
- Reset (synchronous, takes effect at any state, including mid-instruction):
  - State becomes IDLE; ctrl=0; step=0; idle=1; hlt=0; instr_done=0; illegal=0; retired=0.
  - A partially executed instruction is abandoned and does not count as retired.
- ctrl is one-hot per function: at most one bus driver (pc_out, ram_out, ir_out, a_out, b_out, alu_out) is asserted in any cycle.

## Timing
- Single-cycle steps. An instruction occupies 3, 4 or 5 consecutive cycles, with no gap between instructions while run=1.
- IDLE to T1 latency: run=1 sampled at edge N puts T1 in the cycle after edge N. One IDLE cycle follows reset even if run=1 is held throughout.
- run is sampled only in IDLE and in the last step. Dropping run mid-instruction completes the instruction, then the sequencer enters IDLE.
- retired and hlt update on the edge ending the last step, and are visible in the following cycle.
- Simultaneous run=1 and step_req in IDLE: treated as run. step_req is ignored outside IDLE.
- If reset and any other input are asserted together, reset wins.

## Configuration
- CPU_SEQ_SINGLE_STEP_EN:
  - Defined: a step_req pulse in IDLE with hlt=0 and run=0 starts exactly one instruction (T1 next cycle), then the sequencer returns to IDLE regardless of further step_req.
  - Undefined: step_req is ignored and IDLE exits only via run.

## Test plan
- Reset, then run=1, with opcode held at 0010 from T3 onward: T1 appears on the 2nd cycle after reset deasserts; the ctrl sequence is 0x00A, 0x064, 0x088, 0x420, 0x1100; instr_done is high in T5; retired=1.
- Free-run the program LDA, OUT, JMP repeated, with the opcode supplied per instruction: back-to-back 4-, 3- and 3-cycle instructions with no IDLE cycle; retired wraps from 255 to 0 after 256 instructions.
- Opcode 0110 (HLT): hlt=1 and idle=1 after T3; further run=1 and step_req keep the sequencer in IDLE; reset clears hlt.
- Opcode 1000: illegal=1 in T3 only; ctrl=0 in T3; retired increments.
- run dropped during T4 of ADD: T5 completes and the sequencer enters IDLE; with CPU_SEQ_SINGLE_STEP_EN defined, one step_req runs exactly one STA (4 cycles, ctrl 0x210 in T4) and returns to IDLE.
- reset asserted in T4 of STA: in the next cycle ctrl=0, step=0 and retired is unchanged at 0.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Bus between cpu_sequencer and the datapath: opcode/run/step in, control word and status out.
interface cpu_sequencer_if;
  logic [3:0]  opcode;
  logic        run;
  logic        step_req;
  logic [13:0] ctrl;
  logic [2:0]  step;
  logic        idle;
  logic        hlt;
  logic        instr_done;
  logic        illegal;
  logic [7:0]  retired;

  modport slave (
    input  opcode, run, step_req,
    output ctrl, step, idle, hlt, instr_done, illegal, retired
  );

  modport master (
    output opcode, run, step_req,
    input  ctrl, step, idle, hlt, instr_done, illegal, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// T-step control sequencer for the 8-bit bus CPU; drives the one-hot control word.
// Optional CPU_SEQ_SINGLE_STEP_EN: step_req in IDLE runs exactly one instruction.
//
// state | meaning
// IDLE  | stopped; ctrl=0, waits for run (or step_req when enabled)
// T1    | fetch: pc_out, mar_in
// T2    | fetch: ram_out, ir_in, pc_add
// T3    | first execute step (last step for OUT/JMP/HLT/NOP/illegal)
// T4    | second execute step (last for LDA/STA)
// T5    | third execute step (ADD only)
module cpu_sequencer (
  input  logic          clk,
  input  logic          reset,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_STA = 4'b0101;
  localparam logic [3:0] OP_HLT = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // control word bit positions
  localparam int PC_IN  = 0,  PC_OUT = 1,  PC_ADD = 2,  MAR_IN = 3;
  localparam int RAM_IN = 4,  RAM_OUT = 5, IR_IN = 6,   IR_OUT = 7;
  localparam int A_IN   = 8,  A_OUT = 9,   B_IN = 10,   B_OUT = 11;
  localparam int ALU_OUT = 12, OUTPUT_IN = 13;

  state_t      state_q, state_d;
  logic        hlt_q, hlt_d;
  logic [7:0]  retired_q, retired_d;
  logic [13:0] ctrl;
  logic        last_step;
  logic        illegal;
  logic        start;

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_T1: begin
        ctrl[PC_OUT] = 1'b1;
        ctrl[MAR_IN] = 1'b1;
      end
      S_T2: begin
        ctrl[RAM_OUT] = 1'b1;
        ctrl[IR_IN]   = 1'b1;
        ctrl[PC_ADD]  = 1'b1;
      end
      S_T3: begin
        last_step = 1'b1;
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_STA: begin
            ctrl[IR_OUT] = 1'b1;
            ctrl[MAR_IN] = 1'b1;
            last_step    = 1'b0;
          end
          OP_OUT: begin
            ctrl[A_OUT]     = 1'b1;
            ctrl[OUTPUT_IN] = 1'b1;
          end
          OP_JMP: begin
            ctrl[IR_OUT] = 1'b1;
            ctrl[PC_IN]  = 1'b1;
          end
          OP_HLT, OP_NOP: ;
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        // anything other than ADD finishes here, so a stray opcode change cannot stall
        last_step = (bus.opcode != OP_ADD);
        case (bus.opcode)
          OP_LDA: begin
            ctrl[RAM_OUT] = 1'b1;
            ctrl[A_IN]    = 1'b1;
          end
          OP_ADD: begin
            ctrl[RAM_OUT] = 1'b1;
            ctrl[B_IN]    = 1'b1;
          end
          OP_STA: begin
            ctrl[A_OUT]  = 1'b1;
            ctrl[RAM_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        last_step = 1'b1;
        if (bus.opcode == OP_ADD) begin
          ctrl[ALU_OUT] = 1'b1;
          ctrl[A_IN]    = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign start = !hlt_q && (bus.run || bus.step_req);
`else
  assign start = !hlt_q && bus.run;
`endif

  always_comb begin
    state_d   = state_q;
    hlt_d     = hlt_q;
    retired_d = retired_q;
    if (state_q == S_IDLE) begin
      if (start) state_d = S_T1;
    end else if (last_step) begin
      retired_d = retired_q + 8'd1;
      if (state_q == S_T3 && bus.opcode == OP_HLT) begin
        hlt_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = bus.run ? S_T1 : S_IDLE;
      end
    end else begin
      state_d = state_t'(state_q + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hlt_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      hlt_q     <= hlt_d;
      retired_q <= retired_d;
    end
  end

  assign bus.ctrl       = ctrl;
  assign bus.step       = state_q;
  assign bus.idle       = (state_q == S_IDLE);
  assign bus.hlt        = hlt_q;
  assign bus.instr_done = last_step;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer; define CPU_SEQ_SINGLE_STEP_EN to cover single-step.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench in the single IDLE cycle that follows the last reset edge
  task automatic do_reset(input logic run_v);
    reset        = 1'b1;
    bus.run      = run_v;
    bus.step_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // hand-written control words for the test program
  function automatic logic [13:0] ref_ctrl(input logic [3:0] op, input int s);
    logic [13:0] w;
    w = 14'h0000;
    case (s)
      1: w = 14'h000A;
      2: w = 14'h0064;
      3: case (op)
           4'b0001: w = 14'h0088;
           4'b0011: w = 14'h2200;
           4'b0100: w = 14'h0081;
           default: w = 14'h0000;
         endcase
      4: if (op == 4'b0001) w = 14'h0120;
      default: w = 14'h0000;
    endcase
    return w;
  endfunction

  initial begin
    logic [3:0] op;
    int         len;

    bus.opcode   = 4'b0010;
    bus.run      = 1'b0;
    bus.step_req = 1'b0;

    // reset state, then ADD with run dropped during T4
    do_reset(1'b1);
    check_val("rst_idle",    32'(bus.idle), 32'd1);
    check_val("rst_step",    32'(bus.step), 32'd0);
    check_val("rst_ctrl",    32'(bus.ctrl), 32'd0);
    check_val("rst_hlt",     32'(bus.hlt), 32'd0);
    check_val("rst_done",    32'(bus.instr_done), 32'd0);
    check_val("rst_illegal", 32'(bus.illegal), 32'd0);
    check_val("rst_retired", 32'(bus.retired), 32'd0);
    tick();
    check_val("add_t1_step", 32'(bus.step), 32'd1);
    check_val("add_t1_ctrl", 32'(bus.ctrl), 32'h00A);
    tick();
    check_val("add_t2_ctrl", 32'(bus.ctrl), 32'h064);
    tick();
    check_val("add_t3_ctrl", 32'(bus.ctrl), 32'h088);
    check_val("add_t3_done", 32'(bus.instr_done), 32'd0);
    tick();
    check_val("add_t4_ctrl", 32'(bus.ctrl), 32'h420);
    bus.run = 1'b0;
    tick();
    check_val("add_t5_step", 32'(bus.step), 32'd5);
    check_val("add_t5_ctrl", 32'(bus.ctrl), 32'h1100);
    check_val("add_t5_done", 32'(bus.instr_done), 32'd1);
    check_val("add_t5_ret",  32'(bus.retired), 32'd0);
    tick();
    check_val("add_end_idle", 32'(bus.idle), 32'd1);
    check_val("add_end_ret",  32'(bus.retired), 32'd1);
    check_val("add_end_ctrl", 32'(bus.ctrl), 32'd0);

    // free-running LDA, OUT, JMP x256 with retired wrap
    do_reset(1'b1);
    check_val("prog_idle", 32'(bus.idle), 32'd1);
    tick();
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0: begin op = 4'b0001; len = 4; end
        1: begin op = 4'b0011; len = 3; end
        default: begin op = 4'b0100; len = 3; end
      endcase
      bus.opcode = op;
      for (int s = 1; s <= len; s++) begin
        if (s == 1) check_val("prog_retired", 32'(bus.retired), 32'(k % 256));
        check_val("prog_step", 32'(bus.step), 32'(s));
        check_val("prog_done", 32'(bus.instr_done), 32'(s == len));
        if (k < 3) check_val("prog_ctrl", 32'(bus.ctrl), 32'(ref_ctrl(op, s)));
        if (k == 255 && s == len) bus.run = 1'b0;
        tick();
      end
    end
    check_val("prog_end_idle", 32'(bus.idle), 32'd1);
    check_val("prog_wrap",     32'(bus.retired), 32'd0);

    // HLT: sticky, ignores run/step_req, cleared by reset
    bus.opcode = 4'b0110;
    do_reset(1'b1);
    tick();
    tick();
    tick();
    check_val("hlt_t3_step", 32'(bus.step), 32'd3);
    check_val("hlt_t3_ctrl", 32'(bus.ctrl), 32'd0);
    check_val("hlt_t3_done", 32'(bus.instr_done), 32'd1);
    check_val("hlt_t3_hlt",  32'(bus.hlt), 32'd0);
    tick();
    check_val("hlt_idle", 32'(bus.idle), 32'd1);
    check_val("hlt_set",  32'(bus.hlt), 32'd1);
    check_val("hlt_ret",  32'(bus.retired), 32'd1);
    bus.step_req = 1'b1;
    repeat (3) tick();
    bus.step_req = 1'b0;
    check_val("hlt_stay_idle", 32'(bus.idle), 32'd1);
    check_val("hlt_stay_step", 32'(bus.step), 32'd0);
    check_val("hlt_stay_ret",  32'(bus.retired), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("hlt_cleared", 32'(bus.hlt), 32'd0);

    // undefined opcode runs as NOP with illegal in T3
    bus.opcode = 4'b1000;
    do_reset(1'b1);
    tick();
    check_val("ill_t1", 32'(bus.illegal), 32'd0);
    tick();
    check_val("ill_t2", 32'(bus.illegal), 32'd0);
    tick();
    check_val("ill_t3",      32'(bus.illegal), 32'd1);
    check_val("ill_t3_ctrl", 32'(bus.ctrl), 32'd0);
    check_val("ill_t3_done", 32'(bus.instr_done), 32'd1);
    bus.run = 1'b0;
    tick();
    check_val("ill_after",      32'(bus.illegal), 32'd0);
    check_val("ill_after_idle", 32'(bus.idle), 32'd1);
    check_val("ill_after_ret",  32'(bus.retired), 32'd1);

    // single step of STA (or ignored step_req in the default build)
    bus.opcode = 4'b0101;
    do_reset(1'b0);
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    check_val("ss_t1", 32'(bus.step), 32'd1);
    tick();
    tick();
    check_val("ss_t3_ctrl", 32'(bus.ctrl), 32'h088);
    bus.step_req = 1'b1;
    tick();
    check_val("ss_t4_step", 32'(bus.step), 32'd4);
    check_val("ss_t4_ctrl", 32'(bus.ctrl), 32'h210);
    bus.step_req = 1'b0;
    tick();
    check_val("ss_end_idle", 32'(bus.idle), 32'd1);
    check_val("ss_end_ret",  32'(bus.retired), 32'd1);
    tick();
    check_val("ss_stays_idle", 32'(bus.idle), 32'd1);
`else
    check_val("ss_ignored", 32'(bus.idle), 32'd1);
    tick();
    check_val("ss_ignored2", 32'(bus.step), 32'd0);
`endif

    // reset mid-instruction in T4 of STA
    bus.opcode = 4'b0101;
    do_reset(1'b1);
    repeat (4) tick();
    check_val("sta_t4_ctrl", 32'(bus.ctrl), 32'h210);
    reset = 1'b1;
    tick();
    check_val("midrst_ctrl", 32'(bus.ctrl), 32'd0);
    check_val("midrst_step", 32'(bus.step), 32'd0);
    check_val("midrst_ret",  32'(bus.retired), 32'd0);
    check_val("midrst_idle", 32'(bus.idle), 32'd1);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
